// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the ram_4096 port controller.
package ram_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 12;

  // CLEAR sweeps zeros through the RAM; RUN serves client requests.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

  // Write-port pin bundle as presented to the RAM.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Read-response FIFO: holds RAM read data until the client takes it.
// Output data is forced to zero while empty so reset leaves the port quiet.
module ram_rsp_fifo #(
  parameter  int DW    = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A push into a full FIFO is only taken when a pop frees the head slot.
  assign do_push = push_i && (!full || do_pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset because valid gates the output.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_port_ctrl.sv
// Initiator-side controller for ram_4096: clears the RAM after reset, then
// converts valid/ready write and read requests into registered RAM strobes
// and returns read data in order through a back-pressurable response FIFO.
module ram_port_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int RSP_DEPTH      = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  init_done,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_wr_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_rd_address,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  wr_req_t               wr_q, wr_d;
  logic                  ram_write_q, ram_write_d;
  logic                  ram_read_q, ram_read_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pend_q;    // RAM data_out holds a read result this cycle
  logic [CW-1:0]         fifo_count;
  logic                  credit_ok, hazard, rsp_pop;

  // Reserve a FIFO slot for every read still travelling through the RAM, so
  // captured data can never find the FIFO full.
  assign credit_ok = (int'(fifo_count) + int'(ram_read_q) + int'(rd_pend_q)) < RSP_DEPTH;
  // Same-address write and read in one cycle: the write goes first and the
  // read waits a cycle so it observes the new data.
  assign hazard    = wr_req_valid && rd_req_valid && (wr_req_addr == rd_req_addr);

  // Next-state, request acceptance and RAM pin values.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_d         = wr_q;
    ram_write_d  = 1'b0;
    ram_read_d   = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_req_ready = 1'b0;
    rd_req_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        ram_write_d = 1'b1;
        wr_d.addr   = clr_cnt_q;
        wr_d.data   = '0;
        // Stop on the last address instead of wrapping back to zero.
        if (clr_cnt_q == '1) state_d   = RUN;
        else                 clr_cnt_d = clr_cnt_q + 1'b1;
      end
      RUN: begin
        wr_req_ready = !reset;
        rd_req_ready = !reset && credit_ok && !hazard;
        if (wr_req_valid && wr_req_ready) begin
          ram_write_d = 1'b1;
          wr_d.addr   = wr_req_addr;
          wr_d.data   = wr_req_data;
        end
        if (rd_req_valid && rd_req_ready) begin
          ram_read_d = 1'b1;
          rd_addr_d  = rd_req_addr;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, clear counter and registered RAM pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt_q   <= '0;
      wr_q        <= '0;
      ram_write_q <= 1'b0;
      ram_read_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_q        <= wr_d;
      ram_write_q <= ram_write_d;
      ram_read_q  <= ram_read_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= ram_read_q;
    end
  end

  assign rsp_pop = rd_rsp_valid && rd_rsp_ready;

  ram_rsp_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (rd_pend_q),
    .data_i  (ram_data_out),
    .pop_i   (rsp_pop),
    .valid_o (rd_rsp_valid),
    .data_o  (rd_rsp_data),
    .count_o (fifo_count)
  );

  assign init_done      = (state_q == RUN);
  assign ram_write      = ram_write_q;
  assign ram_wr_address = wr_q.addr;
  assign ram_data_in    = wr_q.data;
  assign ram_read       = ram_read_q;
  assign ram_rd_address = rd_addr_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: a behavioural ram_4096, an expected-memory model
// updated in request-acceptance order, and directed plus random traffic.
module tb_ram_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req_valid, wr_req_ready;
  logic [11:0] wr_req_addr;
  logic [63:0] wr_req_data;
  logic        rd_req_valid, rd_req_ready;
  logic [11:0] rd_req_addr;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [63:0] rd_rsp_data;
  logic        init_done;
  logic        ram_write, ram_read;
  logic [11:0] ram_wr_address, ram_rd_address;
  logic [63:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  ram_port_ctrl dut (
    .clock(clk), .reset(reset),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .init_done(init_done),
    .ram_write(ram_write), .ram_wr_address(ram_wr_address), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_rd_address(ram_rd_address), .ram_data_out(ram_data_out)
  );

  // Behavioural ram_4096: write-first, read data one cycle after ram_read.
  logic [63:0] ram_mem [4096];
  initial begin
    ram_data_out = '0;
    forever begin
      @(posedge clk);
      if (ram_read)
        ram_data_out <= (ram_write && ram_wr_address == ram_rd_address) ? ram_data_in
                                                                         : ram_mem[ram_rd_address];
      if (ram_write) ram_mem[ram_wr_address] = ram_data_in;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference state: what memory should hold and which responses are owed.
  logic [63:0] model_mem [4096];
  logic [63:0] exp_q [$];
  bit          mon_en = 0;
  bit          exp_wv = 0, exp_rv = 0, init_seen = 0, hold_v = 0;
  logic [11:0] exp_wa, exp_ra;
  logic [63:0] exp_wd, hold_d;
  int          clr_next = 0;
  int          rsp_cnt = 0;

  // Monitor: samples on the falling edge, checks pins and responses.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (exp_wv) begin
        chk("wr_pin_strobe", ram_write, 1);
        chk("wr_pin_addr", ram_wr_address, exp_wa);
        chk("wr_pin_data", ram_data_in, exp_wd);
      end else if (clr_next < 4096) begin
        if (ram_write === 1'b1) begin
          chk("clr_addr", ram_wr_address, clr_next[11:0]);
          chk("clr_data", ram_data_in, 0);
          model_mem[clr_next] = '0;
          clr_next++;
        end
      end else chk("wr_pin_idle", ram_write, 0);
      chk("rd_pin_strobe", ram_read, exp_rv);
      if (exp_rv) chk("rd_pin_addr", ram_rd_address, exp_ra);
      if (!init_seen && init_done === 1'b1) begin
        init_seen = 1;
        chk("init_sweep_len", clr_next, 4096);
      end
      if (hold_v) begin
        chk("rsp_hold_valid", rd_rsp_valid, 1);
        chk("rsp_hold_data", rd_rsp_data, hold_d);
      end
      if (exp_q.size() == 0) chk("rsp_spurious", rd_rsp_valid, 0);
      else if (rd_rsp_valid && rd_rsp_ready) begin
        chk("rsp_data", rd_rsp_data, exp_q.pop_front());
        rsp_cnt++;
      end
      hold_v = rd_rsp_valid && !rd_rsp_ready;
      hold_d = rd_rsp_data;
      exp_wv = wr_req_valid && wr_req_ready;
      if (exp_wv) begin
        exp_wa = wr_req_addr;
        exp_wd = wr_req_data;
        model_mem[wr_req_addr] = wr_req_data;
      end
      exp_rv = rd_req_valid && rd_req_ready;
      if (exp_rv) begin
        exp_ra = rd_req_addr;
        exp_q.push_back(model_mem[rd_req_addr]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    int n = 0;
    exp_q.delete();
    exp_wv = 0; exp_rv = 0; clr_next = 0; init_seen = 0; hold_v = 0;
    mon_en = 1;
    reset  = 0;
    while (init_done !== 1'b1 && n < 5000) begin tick(); n++; end
    chk("init_done", init_done, 1);
  endtask

  task automatic wr_issue(input logic [11:0] a, input logic [63:0] d);
    wr_req_valid = 1; wr_req_addr = a; wr_req_data = d;
    @(negedge clk);
    chk("wr_ready", wr_req_ready, 1);
    tick();
    wr_req_valid = 0;
  endtask

  task automatic rd_issue(input logic [11:0] a);
    int n = 0;
    rd_req_valid = 1; rd_req_addr = a;
    @(negedge clk);
    while (rd_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("rd_accept", rd_req_ready, 1);
    tick();
    rd_req_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_rv) && n < 200) begin tick(); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  // Called right after the accepting edge with an empty FIFO and ready high.
  task automatic expect_rsp(input string tag, input logic [63:0] exp);
    @(negedge clk); chk({tag, "_c1"}, rd_rsp_valid, 0);
    @(negedge clk); chk({tag, "_c2"}, rd_rsp_valid, 0);
    @(negedge clk); chk({tag, "_c3"}, rd_rsp_valid, 1);
    chk({tag, "_data"}, rd_rsp_data, exp);
    tick();
  endtask

  initial begin
    int acc, idx, stall, base;
    reset = 1; wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0;
    rd_req_valid = 0; rd_req_addr = '0; rd_rsp_ready = 1;
    for (int i = 0; i < 4096; i++) ram_mem[i] = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_req_ready, 0);
    chk("rst_rd_ready", rd_req_ready, 0);
    chk("rst_rsp_valid", rd_rsp_valid, 0);
    chk("rst_rsp_data", rd_rsp_data, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_init", init_done, 0);
    release_reset();

    // Cleared word reads back as zero.
    rd_issue(12'hABC);
    expect_rsp("clr_readback", 64'h0);

    // Write then read, with exact response latency.
    wr_issue(12'h005, 64'hDEAD_BEEF);
    rd_issue(12'h005);
    expect_rsp("wr_rd", 64'hDEAD_BEEF);

    // Same-cycle write and read to one address.
    wr_req_valid = 1; wr_req_addr = 12'h010; wr_req_data = 64'h1111;
    rd_req_valid = 1; rd_req_addr = 12'h010;
    @(negedge clk);
    chk("haz_rd_stall", rd_req_ready, 0);
    chk("haz_wr_ready", wr_req_ready, 1);
    tick();
    wr_req_valid = 0;
    @(negedge clk);
    chk("haz_rd_go", rd_req_ready, 1);
    tick();
    rd_req_valid = 0;
    expect_rsp("haz", 64'h1111);

    // Response back-pressure: only RSP_DEPTH reads may be outstanding.
    for (int i = 0; i < 6; i++) wr_issue(12'h020 + 12'(i), 64'h100 + 64'(i));
    rd_rsp_ready = 0;
    acc = 0; idx = 0;
    rd_req_valid = 1; rd_req_addr = 12'h020;
    repeat (12) begin
      @(negedge clk);
      if (rd_req_ready) begin acc++; idx++; end
      tick();
      if (idx < 6) rd_req_addr = 12'h020 + 12'(idx);
      else rd_req_valid = 0;
    end
    @(negedge clk);
    chk("bp_ready_low", rd_req_ready, 0);
    chk("bp_accepted", acc, 4);
    chk("bp_rsp_valid", rd_rsp_valid, 1);
    tick();
    base = rsp_cnt;
    rd_req_valid = 0; rd_rsp_ready = 1;
    wait_drain();
    chk("bp_rsp_count", rsp_cnt - base, 4);

    // Reset with reads in flight drops them and restarts the sweep.
    rd_rsp_ready = 0;
    rd_issue(12'h020); rd_issue(12'h021); rd_issue(12'h022);
    @(negedge clk);
    chk("prerst_valid", rd_rsp_valid, 1);
    chk("prerst_inflight", ram_read, 1);
    mon_en = 0; reset = 1; rd_rsp_ready = 1;
    tick();
    chk("mid_rst_rsp_valid", rd_rsp_valid, 0);
    chk("mid_rst_ram_read", ram_read, 0);
    chk("mid_rst_ram_write", ram_write, 0);
    chk("mid_rst_init", init_done, 0);
    release_reset();

    // Sustained back-to-back writes then reads.
    stall = 0;
    wr_req_valid = 1;
    for (int i = 0; i < 256; i++) begin
      wr_req_addr = 12'(i); wr_req_data = {$urandom, $urandom};
      @(negedge clk);
      if (!wr_req_ready) stall++;
      tick();
    end
    wr_req_valid = 0;
    chk("wr_sustain_stalls", stall, 0);
    base = rsp_cnt; stall = 0;
    rd_req_valid = 1;
    for (int i = 0; i < 256; i++) begin
      rd_req_addr = 12'(i);
      @(negedge clk);
      if (!rd_req_ready) stall++;
      tick();
    end
    rd_req_valid = 0;
    chk("rd_sustain_stalls", stall, 0);
    wait_drain();
    chk("rd_sustain_rsp", rsp_cnt - base, 256);

    // Random mixed traffic over a small address window.
    repeat (400) begin
      wr_req_valid = 1'($urandom_range(0, 1));
      wr_req_addr  = 12'($urandom_range(0, 15));
      wr_req_data  = {$urandom, $urandom};
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_req_addr  = 12'($urandom_range(0, 15));
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_req_valid = 0; rd_req_valid = 0; rd_rsp_ready = 1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
